// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: data-memory bus controller sitting behind the LSU byte-enable decoder.
// Runs one req/gnt + rvalid bus transaction per load/store, replicates store data
// across lanes and aligns/extends load data for register writeback.
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses
// up front and expose a misalign_o flag alongside done_o.
module lsu_bus_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
`ifdef LSU_MISALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        illegal_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        illegal_req;
  logic [31:0] wdata_rep;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic        timeout_hit;

`ifdef LSU_MISALIGN_CHECK_EN
  logic        misalign_req;
  logic        misalign_q;
`endif

  // Classify the incoming request as legal or not before it is captured.
  always_comb begin
    illegal_req = (be_i == 4'b0000) || (funct3_i == 3'b011) ||
                  (funct3_i[2:1] == 2'b11) || (we_i && funct3_i[2]);
`ifdef LSU_MISALIGN_CHECK_EN
    misalign_req = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    illegal_req  = illegal_req || misalign_req;
`endif
  end

  // Replicate store data into every lane the byte strobes might select.
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   wdata_rep = {4{wdata_i[7:0]}};
      2'b01:   wdata_rep = {2{wdata_i[15:0]}};
      default: wdata_rep = wdata_i;
    endcase
  end

  // Pick the addressed byte/half from the word lane and sign- or zero-extend it.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   lane_byte = bus_rdata_i[7:0];
      2'b01:   lane_byte = bus_rdata_i[15:8];
      2'b10:   lane_byte = bus_rdata_i[23:16];
      default: lane_byte = bus_rdata_i[31:24];
    endcase
    lane_half = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'h000000, lane_byte};
      3'b101:  load_ext = {16'h0000, lane_half};
      default: load_ext = bus_rdata_i;
    endcase
  end

  assign timeout_hit = (cnt == TIMEOUT_LAST);

  // Main access FSM: capture, bus request, response wait, one-cycle completion.
  // Illegal requests pass through one REQ cycle with the bus request masked so
  // the core sees busy_o for a cycle before the error completion.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'b0000;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_i) begin
            we_q      <= we_i;
            funct3_q  <= funct3_i;
            addr_q    <= addr_i;
            wdata_q   <= wdata_rep;
            be_q      <= be_i;
            illegal_q <= illegal_req;
            cnt       <= 8'd0;
            state     <= S_REQ;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_q <= misalign_req;
`endif
          end
        end
        S_REQ: begin
          if (illegal_q || timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= 32'd0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
            if (bus_gnt_i) begin
              state <= S_RSP;
            end
          end
        end
        S_RSP: begin
          if (bus_rvalid_i) begin
            err_q   <= bus_err_i;
            rdata_q <= we_q ? 32'd0 : load_ext;
            state   <= S_DONE;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= 32'd0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (state == S_REQ) || (state == S_RSP);
  assign done_o      = (state == S_DONE);
  assign err_o       = done_o && err_q;
  assign rdata_o     = rdata_q;
  assign bus_req_o   = (state == S_REQ) && !illegal_q;
  assign bus_addr_o  = {addr_q[31:2], 2'b00};
  assign bus_we_o    = we_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_o  = done_o && misalign_q;
`endif

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: scoreboard bench for lsu_bus_ctrl. Each access pushes its
// expected completion into a queue; a monitor pops and compares on done_o.
module tb_lsu_bus_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_gnt_i;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;
`ifdef LSU_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   check_count = 0;
  int   pass_count  = 0;

  lsu_bus_ctrl #(.TIMEOUT(16)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .be_i         (be_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .bus_req_o    (bus_req_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_addr_o   (bus_addr_o),
    .bus_we_o     (bus_we_o),
    .bus_be_o     (bus_be_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .bus_err_i    (bus_err_i)
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    .misalign_o   (misalign_o)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    else
      pass_count++;
  endtask

  function automatic logic isIllegal(logic we, logic [2:0] f3, logic [31:0] addr, logic [3:0] be);
    logic bad;
    bad = (be == 4'b0000) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3 >= 3'b100);
`ifdef LSU_MISALIGN_CHECK_EN
    bad = bad || isMisaligned(f3, addr);
`else
    if (addr == 32'hFFFF_FFFF && addr != 32'hFFFF_FFFF) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic isMisaligned(logic [2:0] f3, logic [31:0] addr);
    int sz;
    sz = (f3 == 3'b001 || f3 == 3'b101) ? 2 : (f3 == 3'b010) ? 4 : 1;
    return (addr % sz) != 0;
  endfunction

  function automatic logic [31:0] storeModel(logic [2:0] f3, logic [31:0] wd);
    logic [31:0] b;
    logic [31:0] h;
    b = {24'd0, wd[7:0]};
    h = {16'd0, wd[15:0]};
    if (f3 == 3'b000) return b * 32'h0101_0101;
    if (f3 == 3'b001) return h * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] loadModel(logic [2:0] f3, logic [31:0] addr, logic [31:0] raw);
    logic [31:0] v;
    v = raw >> (8 * (addr % 4));
    case (f3)
      3'b000:  return 32'($signed(v[7:0]));
      3'b001:  return 32'($signed(v[15:0]));
      3'b100:  return v & 32'h0000_00FF;
      3'b101:  return v & 32'h0000_FFFF;
      default: return raw;
    endcase
  endfunction

  // Scoreboard monitor: every completion must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (rst_n_i === 1'b1 && done_o === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.tag, "_err"}, {31'd0, err_o}, {31'd0, e.err});
        if (!e.err) checkOutput({e.tag, "_rdata"}, rdata_o, e.rdata);
        checkOutput({e.tag, "_busy_in_done"}, {31'd0, busy_o}, 32'd0);
`ifdef LSU_MISALIGN_CHECK_EN
        checkOutput({e.tag, "_misalign"}, {31'd0, misalign_o}, {31'd0, e.mis});
`endif
      end
    end
  end

  // One complete access: request at cycle 0, grant/response at the given cycles
  // (gnt_cyc < 0 means the grant never comes), with optional stray rvalid in the
  // grant cycle and an ignored second request while busy.
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                               input int gnt_cyc, input int rv_cyc, input logic [31:0] raw,
                               input logic berr, input logic stray, input logic extra_req);
    exp_t e;
    logic ill;
    logic tmo;
    int   exp_done;
    int   exp_reqs;
    int   done_at;
    int   req_cnt;
    ill = isIllegal(we, f3, addr, be);
    tmo = !ill && (gnt_cyc < 1);
    exp_done = ill ? 2 : tmo ? 17 : rv_cyc + 1;
    exp_reqs = ill ? 0 : tmo ? 16 : gnt_cyc;
    e.tag   = tag;
    e.err   = ill || tmo || berr;
    e.rdata = we ? 32'd0 : loadModel(f3, addr, raw);
    e.mis   = isMisaligned(f3, addr) && !we ? 1'b1 : isMisaligned(f3, addr);
    sb.push_back(e);

    @(negedge clk_i);
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd; be_i = be;
    done_at = -1;
    req_cnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk_i);
      req_i = (extra_req && cyc == 2);
      if (bus_req_o) req_cnt++;
      if (cyc == 1) begin
        checkOutput({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        if (!ill) begin
          checkOutput({tag, "_bus_addr"}, bus_addr_o, addr & 32'hFFFF_FFFC);
          checkOutput({tag, "_bus_be"}, {28'd0, bus_be_o}, {28'd0, be});
          checkOutput({tag, "_bus_we"}, {31'd0, bus_we_o}, {31'd0, we});
          if (we) checkOutput({tag, "_bus_wdata"}, bus_wdata_o, storeModel(f3, wd));
        end
      end
      if (done_o) begin
        done_at = cyc;
        break;
      end
      bus_gnt_i    = (cyc == gnt_cyc);
      bus_rvalid_i = (cyc == rv_cyc) || (stray && cyc == gnt_cyc);
      bus_rdata_i  = (stray && cyc == gnt_cyc) ? 32'h5A5A_5A5A : raw;
      bus_err_i    = (cyc == rv_cyc) ? berr : 1'b0;
    end
    req_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    checkOutput({tag, "_done_cycle"}, done_at, exp_done);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      if (bus_req_o) req_cnt++;
      if (done_o) checkOutput({tag, "_extra_done"}, 32'd1, 32'd0);
    end
    checkOutput({tag, "_bus_req_cycles"}, req_cnt, exp_reqs);
    if (!e.err) checkOutput({tag, "_rdata_hold"}, rdata_o, e.rdata);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit saw_done;
    rst_n_i = 1'b0; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000; addr_i = 32'd0;
    wdata_i = 32'd0; be_i = 4'b0000; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    bus_rdata_i = 32'd0; bus_err_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("reset_busy",     {31'd0, busy_o},    32'd0);
    checkOutput("reset_done",     {31'd0, done_o},    32'd0);
    checkOutput("reset_err",      {31'd0, err_o},     32'd0);
    checkOutput("reset_bus_req",  {31'd0, bus_req_o}, 32'd0);
    checkOutput("reset_rdata",    rdata_o,            32'd0);
    checkOutput("reset_bus_addr", bus_addr_o,         32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    applyStimulus("lw_basic",  1'b0, 3'b010, 32'h100, 32'd0,        4'b1111, 1, 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    applyStimulus("lb_sign",   1'b0, 3'b000, 32'h103, 32'd0,        4'b1000, 1, 2, 32'h8012_3456, 1'b0, 1'b0, 1'b0);
    applyStimulus("lbu_zero",  1'b0, 3'b100, 32'h103, 32'd0,        4'b1000, 1, 2, 32'h8012_3456, 1'b0, 1'b0, 1'b0);
    applyStimulus("sh_rep",    1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 4'b1100, 2, 4, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus("sb_rep",    1'b1, 3'b000, 32'h101, 32'h0000_0055, 4'b0010, 1, 3, 32'd0,        1'b0, 1'b0, 1'b0);
    applyStimulus("lh_sign",   1'b0, 3'b001, 32'h102, 32'd0,        4'b1100, 3, 5, 32'h8001_7777, 1'b0, 1'b0, 1'b0);
    applyStimulus("lhu_zero",  1'b0, 3'b101, 32'h102, 32'd0,        4'b1100, 1, 2, 32'h8001_7777, 1'b0, 1'b0, 1'b0);
    applyStimulus("lw_timeout",1'b0, 3'b010, 32'h300, 32'd0,        4'b1111, -1, -1, 32'd0,       1'b0, 1'b0, 1'b0);
    applyStimulus("lw_buserr", 1'b0, 3'b010, 32'h400, 32'd0,        4'b1111, 1, 3, 32'h1111_2222, 1'b1, 1'b0, 1'b0);
    applyStimulus("lw_busy_req",1'b0,3'b010, 32'h500, 32'd0,        4'b1111, 1, 2, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
    applyStimulus("lw_stray",  1'b0, 3'b010, 32'h600, 32'd0,        4'b1111, 1, 3, 32'h0BAD_CAFE, 1'b0, 1'b1, 1'b0);
    applyStimulus("lh_be0",    1'b0, 3'b001, 32'h101, 32'd0,        4'b0000, 1, 2, 32'd0,        1'b0, 1'b0, 1'b0);
    applyStimulus("bad_f3",    1'b0, 3'b011, 32'h100, 32'd0,        4'b1111, 1, 2, 32'd0,        1'b0, 1'b0, 1'b0);
    applyStimulus("sbu_bad",   1'b1, 3'b100, 32'h100, 32'h0000_00AA, 4'b0001, 1, 2, 32'd0,        1'b0, 1'b0, 1'b0);

    // Reset in the middle of an access drops the bus request and any response.
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h700; be_i = 4'b1111;
    @(negedge clk_i);
    req_i = 1'b0;
    checkOutput("midrst_req_before", {31'd0, bus_req_o}, 32'd1);
    #2 rst_n_i = 1'b0;
    #1 checkOutput("midrst_req_after", {31'd0, bus_req_o}, 32'd0);
    checkOutput("midrst_busy_after", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    saw_done = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      bus_rvalid_i = 1'b0;
      if (done_o || bus_req_o) saw_done = 1'b1;
    end
    checkOutput("midrst_no_activity", {31'd0, saw_done}, 32'd0);

    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
